// File: rtl/spectral_peak_detect.sv
// Per-band spectral peak search over one FFT magnitude frame.
// Reports max magnitude and its bin per band, with an overrun/sync error flag.
module spectral_peak_detect #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned FFT_LEN = 64,
  parameter int unsigned N_BANDS = 2,
  parameter int unsigned BIN_W   = $clog2(FFT_LEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  input  logic [N_BANDS*BIN_W-1:0]   band_lo,
  input  logic [N_BANDS*BIN_W-1:0]   band_hi,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N_BANDS*DATA_W-1:0]  m_peak,
  output logic [N_BANDS*BIN_W-1:0]   m_bin,
  output logic [N_BANDS-1:0]         m_hit,
  output logic                       overrun,
  output logic                       sync_err,
  input  logic                       clr_err
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);

  logic [BIN_W-1:0]          cnt_q, cnt_d;
  logic [N_BANDS*BIN_W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [N_BANDS*DATA_W-1:0] run_max_q, run_max_d;
  logic [N_BANDS*BIN_W-1:0]  run_bin_q, run_bin_d;
  logic [N_BANDS-1:0]        run_hit_q, run_hit_d;
  logic                      m_valid_q, m_valid_d;
  logic [N_BANDS*DATA_W-1:0] m_peak_q, m_peak_d;
  logic [N_BANDS*BIN_W-1:0]  m_bin_q, m_bin_d;
  logic [N_BANDS-1:0]        m_hit_q, m_hit_d;
  logic                      overrun_q, overrun_d;
  logic                      sync_err_q, sync_err_d;

  logic [N_BANDS*BIN_W-1:0]  lo_eff, hi_eff;
  logic [N_BANDS*DATA_W-1:0] upd_max;
  logic [N_BANDS*BIN_W-1:0]  upd_bin;
  logic [N_BANDS-1:0]        upd_hit;
  logic                      frame_done, frame_drop;

  // Window bounds are taken live on bin 0 and from the captured copy afterwards
  assign lo_eff     = (cnt_q == '0) ? band_lo : lo_q;
  assign hi_eff     = (cnt_q == '0) ? band_hi : hi_q;
  assign frame_done = s_valid && (cnt_q == LAST_BIN);
  assign frame_drop = s_valid && s_last && (cnt_q != LAST_BIN);

  always_comb begin
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    run_max_d  = run_max_q;
    run_bin_d  = run_bin_q;
    run_hit_d  = run_hit_q;
    m_valid_d  = m_valid_q;
    m_peak_d   = m_peak_q;
    m_bin_d    = m_bin_q;
    m_hit_d    = m_hit_q;
    overrun_d  = overrun_q;
    sync_err_d = sync_err_q;
    upd_max    = run_max_q;
    upd_bin    = run_bin_q;
    upd_hit    = run_hit_q;

    // Strict greater-than keeps the earliest bin on ties
    for (int unsigned k = 0; k < N_BANDS; k++) begin
      if (s_valid &&
          (cnt_q >= lo_eff[k*BIN_W +: BIN_W]) &&
          (cnt_q <= hi_eff[k*BIN_W +: BIN_W]) &&
          (!run_hit_q[k] || (s_data > run_max_q[k*DATA_W +: DATA_W]))) begin
        upd_max[k*DATA_W +: DATA_W] = s_data;
        upd_bin[k*BIN_W +: BIN_W]   = cnt_q;
        upd_hit[k]                  = 1'b1;
      end
    end

    if (s_valid) begin
      if (cnt_q == '0) begin
        lo_d = band_lo;
        hi_d = band_hi;
      end
      cnt_d = (frame_done || frame_drop) ? '0 : cnt_q + BIN_W'(1);
    end

    if (frame_done || frame_drop) begin
      run_max_d = '0;
      run_bin_d = '0;
      run_hit_d = '0;
    end else begin
      run_max_d = upd_max;
      run_bin_d = upd_bin;
      run_hit_d = upd_hit;
    end

    if (clr_err) begin
      overrun_d  = 1'b0;
      sync_err_d = 1'b0;
    end
    if (frame_drop || (frame_done && !s_last)) sync_err_d = 1'b1;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (frame_done) begin
      if (!m_valid_q || m_ready) begin
        m_valid_d = 1'b1;
        m_peak_d  = upd_max;
        m_bin_d   = upd_bin;
        m_hit_d   = upd_hit;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      run_max_q  <= '0;
      run_bin_q  <= '0;
      run_hit_q  <= '0;
      m_valid_q  <= 1'b0;
      m_peak_q   <= '0;
      m_bin_q    <= '0;
      m_hit_q    <= '0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      run_max_q  <= run_max_d;
      run_bin_q  <= run_bin_d;
      run_hit_q  <= run_hit_d;
      m_valid_q  <= m_valid_d;
      m_peak_q   <= m_peak_d;
      m_bin_q    <= m_bin_d;
      m_hit_q    <= m_hit_d;
      overrun_q  <= overrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_peak   = m_peak_q;
  assign m_bin    = m_bin_q;
  assign m_hit    = m_hit_q;
  assign overrun  = overrun_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_spectral_peak_detect.sv
// Bench for spectral_peak_detect: table of frames with hand-derived results
// checked through a result queue, plus overrun, sync-error and reset sequences.
module tb_spectral_peak_detect;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned FFT_LEN = 64;
  localparam int unsigned N_BANDS = 2;
  localparam int unsigned BIN_W   = 6;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      s_valid;
  logic [DATA_W-1:0]         s_data;
  logic                      s_last;
  logic [N_BANDS*BIN_W-1:0]  band_lo, band_hi;
  logic                      m_valid;
  logic                      m_ready;
  logic [N_BANDS*DATA_W-1:0] m_peak;
  logic [N_BANDS*BIN_W-1:0]  m_bin;
  logic [N_BANDS-1:0]        m_hit;
  logic                      overrun, sync_err, clr_err;

  spectral_peak_detect #(
    .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .N_BANDS(N_BANDS), .BIN_W(BIN_W)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .band_lo(band_lo), .band_hi(band_hi), .m_valid(m_valid), .m_ready(m_ready),
    .m_peak(m_peak), .m_bin(m_bin), .m_hit(m_hit), .overrun(overrun),
    .sync_err(sync_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pat;
    logic [5:0] lo0, hi0, lo1, hi1;
    logic [11:0] pk0, pk1;
    logic [5:0] bn0, bn1;
    logic [1:0] hit;
  } vec_t;

  typedef struct {
    logic [23:0] peak;
    logic [11:0] bin;
    logic [1:0]  hit;
  } res_t;

  vec_t vecs[6];
  res_t exp_q[$];
  res_t mon_r;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t to_res(input vec_t v);
    res_t r;
    r.peak = {v.pk1, v.pk0};
    r.bin  = {v.bn1, v.bn0};
    r.hit  = v.hit;
    return r;
  endfunction

  function automatic logic [11:0] pattern(input int p, input int b);
    case (p)
      0:       return 12'(b);
      1:       return (b == 10 || b == 12) ? 12'd100 : 12'd5;
      2:       return 12'(63 - b);
      3:       return 12'd7;
      default: return (b == 2) ? 12'hFFF : 12'd0;
    endcase
  endfunction

  // Drives n beats starting at bin 0; bands are scrambled after bin 0 to prove capture
  task automatic send(input vec_t v, input int n, input bit end_last, input bit gaps,
                      input bit clr_on_end);
    band_lo = {v.lo1, v.lo0};
    band_hi = {v.hi1, v.hi0};
    for (int b = 0; b < n; b++) begin
      s_valid = 1'b1;
      s_data  = pattern(v.pat, b);
      s_last  = (b == n - 1) && end_last;
      clr_err = (b == n - 1) && clr_on_end;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      clr_err = 1'b0;
      if (b == 0) begin
        band_lo = 12'($urandom);
        band_hi = 12'($urandom);
      end
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted result must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(1), 64'(0));
      end else begin
        mon_r = exp_q.pop_front();
        check("peak", 64'(m_peak), 64'(mon_r.peak));
        check("bin",  64'(m_bin),  64'(mon_r.bin));
        check("hit",  64'(m_hit),  64'(mon_r.hit));
      end
    end
  end

  initial begin
    vecs[0] = '{0, 6'd8,  6'd15, 6'd40, 6'd47, 12'd15,  12'd47, 6'd15, 6'd47, 2'b11};
    vecs[1] = '{1, 6'd10, 6'd12, 6'd20, 6'd5,  12'd100, 12'd0,  6'd10, 6'd0,  2'b01};
    vecs[2] = '{2, 6'd0,  6'd63, 6'd30, 6'd30, 12'd63,  12'd33, 6'd0,  6'd30, 2'b11};
    vecs[3] = '{3, 6'd5,  6'd9,  6'd63, 6'd63, 12'd7,   12'd7,  6'd5,  6'd63, 2'b11};
    vecs[4] = '{1, 6'd11, 6'd11, 6'd0,  6'd9,  12'd5,   12'd5,  6'd11, 6'd0,  2'b11};
    vecs[5] = '{4, 6'd2,  6'd2,  6'd3,  6'd63, 12'hFFF, 12'd0,  6'd2,  6'd3,  2'b11};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    band_lo = '0; band_hi = '0; m_ready = 1'b1; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid",  64'(m_valid),  64'(0));
    check("rst_peak",     64'(m_peak),   64'(0));
    check("rst_overrun",  64'(overrun),  64'(0));
    check("rst_sync_err", 64'(sync_err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      exp_q.push_back(to_res(vecs[i]));
      send(vecs[i], FFT_LEN, 1'b1, (i % 2) == 1, 1'b0);
    end
    drain();

    // Overrun: consumer stalls across two frames, first result must hold
    m_ready = 1'b0;
    exp_q.push_back(to_res(vecs[0]));
    send(vecs[0], FFT_LEN, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_valid",   64'(m_valid), 64'(1));
    check("ovr_pre",     64'(overrun), 64'(0));
    @(posedge clk); #1;
    send(vecs[2], FFT_LEN, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_set",     64'(overrun), 64'(1));
    check("ovr_hold_pk", 64'(m_peak),  64'({12'd47, 12'd15}));
    check("ovr_hold_bn", 64'(m_bin),   64'({6'd47, 6'd15}));
    @(posedge clk); #1;
    clr_pulse();
    @(negedge clk);
    check("ovr_clr",     64'(overrun), 64'(0));
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain();
    @(negedge clk);
    check("ovr_released", 64'(m_valid), 64'(0));
    @(posedge clk); #1;

    // Early s_last discards the frame; a clear in the same cycle loses to the set
    send(vecs[0], 31, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sync_no_valid", 64'(m_valid),  64'(0));
    check("sync_set",      64'(sync_err), 64'(1));
    @(posedge clk); #1;
    exp_q.push_back(to_res(vecs[0]));
    send(vecs[0], FFT_LEN, 1'b1, 1'b0, 1'b0);
    drain();
    clr_pulse();
    @(negedge clk);
    check("sync_clr", 64'(sync_err), 64'(0));
    @(posedge clk); #1;

    // Missing s_last on the final bin still completes but flags sync_err
    exp_q.push_back(to_res(vecs[3]));
    send(vecs[3], FFT_LEN, 1'b0, 1'b0, 1'b0);
    drain();
    @(negedge clk);
    check("nolast_sync", 64'(sync_err), 64'(1));
    @(posedge clk); #1;

    // Reset mid-frame with pending result and sticky flags set
    m_ready = 1'b0;
    send(vecs[0], FFT_LEN, 1'b1, 1'b0, 1'b0);
    send(vecs[0], FFT_LEN, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_rst_valid",   64'(m_valid), 64'(1));
    check("pre_rst_overrun", 64'(overrun), 64'(1));
    @(posedge clk); #1;
    send(vecs[2], 20, 1'b0, 1'b1, 1'b0);
    s_valid = 1'b1;
    s_data  = pattern(2, 20);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid",    64'(m_valid),  64'(0));
    check("arst_peak",     64'(m_peak),   64'(0));
    check("arst_bin",      64'(m_bin),    64'(0));
    check("arst_hit",      64'(m_hit),    64'(0));
    check("arst_overrun",  64'(overrun),  64'(0));
    check("arst_sync_err", 64'(sync_err), 64'(0));
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(to_res(vecs[2]));
    send(vecs[2], FFT_LEN, 1'b1, 1'b1, 1'b0);
    drain();

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
